// File: rtl/eeg_pea_omux.sv
// Output collector for the PE array: round-robin arbitration of per-PE result streams onto the
// single output-RAM write port, with layer-completion tracking. Optional counters: EEG_OMUX_STAT_EN.
module eeg_pea_omux #(
  parameter int PE_ROW      = 4,
  parameter int PE_COL      = 4,
  parameter int DATA_OUT_DW = 8,
  parameter int OMUX_ADD_AW = 8,
  parameter int ORAM_ADD_AW = 10,
  parameter int STAT_DW     = 16
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 CFG_START,
  input  logic [PE_ROW*PE_COL-1:0]             CFG_PE_MSK,
  input  logic [ORAM_ADD_AW-1:0]               CFG_OUT_BASE,
  output logic                                 IS_IDLE,
  output logic                                 DONE,
  input  logic [PE_ROW*PE_COL-1:0]             IN_VLD,
  output logic [PE_ROW*PE_COL-1:0]             IN_RDY,
  input  logic [PE_ROW*PE_COL-1:0]             IN_LST,
  input  logic [PE_ROW*PE_COL*DATA_OUT_DW-1:0] IN_DAT,
  input  logic [PE_ROW*PE_COL*OMUX_ADD_AW-1:0] IN_ADD,
  output logic                                 ORAM_VLD,
  input  logic                                 ORAM_RDY,
  output logic [ORAM_ADD_AW-1:0]               ORAM_ADD,
  output logic [DATA_OUT_DW-1:0]               ORAM_DAT,
  output logic [STAT_DW-1:0]                   STAT_WR_CNT,
  output logic [STAT_DW-1:0]                   STAT_STL_CNT
);

  localparam int unsigned PE_NUM = $unsigned(PE_ROW * PE_COL);
  localparam int          PTR_W  = (PE_NUM > 1) ? $clog2(PE_NUM) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FIN
  } state_t;

  state_t                   r_state;
  logic [PE_NUM-1:0]        r_msk;
  logic [PE_NUM-1:0]        r_lst;
  logic [ORAM_ADD_AW-1:0]   r_base;
  logic [PTR_W-1:0]         r_ptr;
  logic                     r_ovld;
  logic [ORAM_ADD_AW-1:0]   r_oadd;
  logic [DATA_OUT_DW-1:0]   r_odat;

  logic [DATA_OUT_DW-1:0]   w_dat [PE_NUM];
  logic [OMUX_ADD_AW-1:0]   w_add [PE_NUM];
  logic [PE_NUM-1:0]        w_elig;
  logic [PE_NUM-1:0]        w_rdy;
  logic [PTR_W-1:0]         w_grant;
  logic [PTR_W-1:0]         w_ptr_nxt;
  logic                     w_found;
  logic                     w_acc;
  logic                     w_all_done;
  logic [ORAM_ADD_AW-1:0]   w_oadd;

  for (genvar gi = 0; gi < PE_NUM; gi++) begin : g_unpack
    assign w_dat[gi] = IN_DAT[gi*DATA_OUT_DW +: DATA_OUT_DW];
    assign w_add[gi] = IN_ADD[gi*OMUX_ADD_AW +: OMUX_ADD_AW];
  end

  assign w_elig = (r_state == ST_RUN) ? (r_msk & IN_VLD & ~r_lst) : '0;

  // Rotating priority: scan from the pointer upwards, wrapping at PE_NUM.
  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    for (int unsigned k = 0; k < PE_NUM; k++) begin
      int unsigned idx;
      idx = 32'(r_ptr) + k;
      if (idx >= PE_NUM) idx = idx - PE_NUM;
      if (!w_found && w_elig[idx[PTR_W-1:0]]) begin
        w_found = 1'b1;
        w_grant = idx[PTR_W-1:0];
      end
    end
  end

  assign w_acc      = w_found & (~r_ovld | ORAM_RDY);
  assign w_ptr_nxt  = (w_grant == PTR_W'(PE_NUM - 1)) ? '0 : w_grant + 1'b1;
  assign w_all_done = &(r_lst | ~r_msk);
  assign w_oadd     = r_base + ORAM_ADD_AW'(w_add[w_grant]);

  always_comb begin
    w_rdy          = '0;
    w_rdy[w_grant] = w_acc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_msk   <= '0;
      r_lst   <= '0;
      r_base  <= '0;
      r_ptr   <= '0;
      r_ovld  <= 1'b0;
      r_oadd  <= '0;
      r_odat  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (CFG_START) begin
            r_state <= ST_RUN;
            r_msk   <= CFG_PE_MSK;
            r_base  <= CFG_OUT_BASE;
            r_lst   <= '0;
          end
        end
        ST_RUN: begin
          if (w_all_done && !r_ovld) r_state <= ST_FIN;
        end
        ST_FIN:  r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase

      if (w_acc) begin
        r_ovld <= 1'b1;
        r_oadd <= w_oadd;
        r_odat <= w_dat[w_grant];
        r_ptr  <= w_ptr_nxt;
        if (IN_LST[w_grant]) r_lst[w_grant] <= 1'b1;
      end else if (ORAM_RDY) begin
        r_ovld <= 1'b0;
      end
    end
  end

  assign IS_IDLE  = (r_state == ST_IDLE);
  assign DONE     = (r_state == ST_FIN);
  assign IN_RDY   = w_rdy;
  assign ORAM_VLD = r_ovld;
  assign ORAM_ADD = r_oadd;
  assign ORAM_DAT = r_odat;

`ifdef EEG_OMUX_STAT_EN
  logic [STAT_DW-1:0] r_wr_cnt;
  logic [STAT_DW-1:0] r_stl_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_cnt  <= '0;
      r_stl_cnt <= '0;
    end else if (r_state == ST_IDLE && CFG_START) begin
      r_wr_cnt  <= '0;
      r_stl_cnt <= '0;
    end else begin
      if (r_ovld && ORAM_RDY && r_wr_cnt != '1)   r_wr_cnt  <= r_wr_cnt + 1'b1;
      if (r_ovld && !ORAM_RDY && r_stl_cnt != '1) r_stl_cnt <= r_stl_cnt + 1'b1;
    end
  end

  assign STAT_WR_CNT  = r_wr_cnt;
  assign STAT_STL_CNT = r_stl_cnt;
`else
  assign STAT_WR_CNT  = '0;
  assign STAT_STL_CNT = '0;
`endif

endmodule

// File: tb/tb_eeg_pea_omux.sv
// Scoreboard bench for eeg_pea_omux: a per-layer behavioural model predicts grants and queues the
// expected RAM writes; an independent monitor pops and checks every write handshake.
module tb_eeg_pea_omux;
  localparam int N = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         cfg_start;
  logic [15:0]  cfg_msk;
  logic [9:0]   cfg_base;
  logic         is_idle, done;
  logic [15:0]  in_vld, in_rdy, in_lst;
  logic [127:0] in_dat, in_add;
  logic         oram_vld, oram_rdy;
  logic [9:0]   oram_add;
  logic [7:0]   oram_dat;
  logic [15:0]  st_wr, st_stl;

  always #5 clk = ~clk;

  eeg_pea_omux #(
    .PE_ROW(4), .PE_COL(4), .DATA_OUT_DW(8), .OMUX_ADD_AW(8), .ORAM_ADD_AW(10), .STAT_DW(16)
  ) dut (
    .clk(clk), .rst(rst), .CFG_START(cfg_start), .CFG_PE_MSK(cfg_msk), .CFG_OUT_BASE(cfg_base),
    .IS_IDLE(is_idle), .DONE(done), .IN_VLD(in_vld), .IN_RDY(in_rdy), .IN_LST(in_lst),
    .IN_DAT(in_dat), .IN_ADD(in_add), .ORAM_VLD(oram_vld), .ORAM_RDY(oram_rdy),
    .ORAM_ADD(oram_add), .ORAM_DAT(oram_dat), .STAT_WR_CNT(st_wr), .STAT_STL_CNT(st_stl)
  );

  typedef struct packed {
    logic [9:0] a;
    logic [7:0] d;
  } beat_t;

  int n_tests = 0;
  int n_fail  = 0;
  beat_t sb[$];

  // Per-channel beat lists for the current layer
  int         nb [N];
  int         hd [N];
  logic [7:0] bdat [N][8];
  logic [7:0] badd [N][8];
  logic [15:0] l_msk;
  logic [9:0]  l_base;
  int vpct, rpct, stall_left;

  // Behavioural model of the collector
  int          m_phase;  // 0 idle, 1 collecting, 2 done pulse
  logic [15:0] m_msk, m_lst;
  logic [9:0]  m_base;
  int          m_ptr;
  bit          m_full;
  int          m_wr, m_stl;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_msk = '0; m_lst = '0; m_base = '0; m_ptr = 0;
    m_full = 1'b0; m_wr = 0; m_stl = 0;
    sb.delete();
  endtask

  task automatic eval();
    logic [15:0] exp_rdy;
    int g, ph_n;
    bit can, acc;
    beat_t b;
    exp_rdy = '0;
    g = -1;
    can = !m_full || oram_rdy;
    if (m_phase == 1)
      for (int k = 0; k < N; k++) begin
        int i;
        i = (m_ptr + k) % N;
        if (g < 0 && m_msk[i] && in_vld[i] && !m_lst[i]) g = i;
      end
    acc = (g >= 0) && can;
    if (acc) exp_rdy[g] = 1'b1;
    chk("in_rdy", 32'(in_rdy), 32'(exp_rdy));
    chk("is_idle", 32'(is_idle), 32'(m_phase == 0));
    chk("done", 32'(done), 32'(m_phase == 2));
    if (m_phase == 2) begin
`ifdef EEG_OMUX_STAT_EN
      chk("stat_wr", 32'(st_wr), 32'(m_wr));
      chk("stat_stl", 32'(st_stl), 32'(m_stl));
`else
      chk("stat_wr", 32'(st_wr), 32'd0);
      chk("stat_stl", 32'(st_stl), 32'd0);
`endif
    end

    ph_n = m_phase;
    case (m_phase)
      0: if (cfg_start) ph_n = 1;
      1: if (((m_lst | ~m_msk) == 16'hFFFF) && !m_full) ph_n = 2;
      default: ph_n = 0;
    endcase

    if (m_phase == 0 && cfg_start) begin
      m_wr = 0; m_stl = 0;
    end else begin
      if (m_full && oram_rdy && m_wr < 65535) m_wr++;
      if (m_full && !oram_rdy && m_stl < 65535) m_stl++;
    end

    if (acc) begin
      b.a = 10'((int'(m_base) + int'(in_add[g*8 +: 8])) % 1024);
      b.d = in_dat[g*8 +: 8];
      sb.push_back(b);
      if (in_lst[g]) m_lst[g] = 1'b1;
      m_ptr = (g + 1) % N;
      hd[g]++;
      m_full = 1'b1;
    end else if (oram_rdy) begin
      m_full = 1'b0;
    end

    if (m_phase == 0 && cfg_start) begin
      m_msk = cfg_msk; m_base = cfg_base; m_lst = '0;
    end
    m_phase = ph_n;
  endtask

  task automatic step(input bit start);
    @(negedge clk);
    cfg_start = start;
    if (m_phase == 0) begin
      cfg_msk = l_msk; cfg_base = l_base;
    end else begin
      cfg_msk = 16'($urandom); cfg_base = 10'($urandom);
    end
    for (int i = 0; i < N; i++) begin
      if (l_msk[i] && hd[i] < nb[i]) begin
        in_vld[i]       = ($urandom_range(99) < vpct);
        in_dat[i*8 +: 8] = bdat[i][hd[i]];
        in_add[i*8 +: 8] = badd[i][hd[i]];
        in_lst[i]       = (hd[i] == nb[i] - 1);
      end else begin
        // Masked or already-finished channels keep requesting with junk
        in_vld[i]       = 1'b1;
        in_dat[i*8 +: 8] = 8'($urandom);
        in_add[i*8 +: 8] = 8'($urandom);
        in_lst[i]       = 1'($urandom_range(1));
      end
    end
    if (stall_left > 0 && m_full) begin
      oram_rdy = 1'b0;
      stall_left--;
    end else begin
      oram_rdy = ($urandom_range(99) < rpct);
    end
    #3;
    eval();
  endtask

  task automatic set_beats(input logic [15:0] msk, input int maxb);
    for (int i = 0; i < N; i++) begin
      nb[i] = msk[i] ? int'($urandom_range(maxb, 1)) : 0;
      hd[i] = 0;
      for (int j = 0; j < 8; j++) begin
        bdat[i][j] = 8'($urandom);
        badd[i][j] = 8'($urandom);
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; cfg_start = 1'b0; in_vld = '0; oram_rdy = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_is_idle", 32'(is_idle), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_in_rdy", 32'(in_rdy), 32'd0);
    chk("rst_oram_vld", 32'(oram_vld), 32'd0);
    chk("rst_oram_add", 32'(oram_add), 32'd0);
    chk("rst_oram_dat", 32'(oram_dat), 32'd0);
    chk("rst_stat_wr", 32'(st_wr), 32'd0);
    chk("rst_stat_stl", 32'(st_stl), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_layer(input logic [15:0] msk, input logic [9:0] base, input int vp, input int rp);
    int cyc;
    l_msk = msk; l_base = base; vpct = vp; rpct = rp;
    step(1'b1);
    cyc = 0;
    while (m_phase != 0 && cyc < 2000) begin
      step($urandom_range(7) == 0);
      cyc++;
    end
    if (m_phase != 0) begin
      n_tests++; n_fail++;
      $display("FAIL layer_timeout actual phase=%0d required=0", m_phase);
      do_reset();
    end
  endtask

  // Monitor: every write handshake must match the scoreboard head; stalled beats must hold.
  initial begin
    bit pv;
    logic [9:0] pa;
    logic [7:0] pd;
    beat_t e;
    pv = 1'b0; pa = '0; pd = '0;
    forever begin
      @(negedge clk);
      #4;
      if (rst) begin
        pv = 1'b0;
      end else begin
        if (pv) begin
          chk("hold_vld", 32'(oram_vld), 32'd1);
          chk("hold_add", 32'(oram_add), 32'(pa));
          chk("hold_dat", 32'(oram_dat), 32'(pd));
        end
        if (oram_vld && oram_rdy) begin
          if (sb.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL unexpected_write actual add=%0h dat=%0h required=no write", oram_add, oram_dat);
          end else begin
            e = sb.pop_front();
            chk("oram_add", 32'(oram_add), 32'(e.a));
            chk("oram_dat", 32'(oram_dat), 32'(e.d));
          end
        end
        pv = oram_vld && !oram_rdy;
        pa = oram_add;
        pd = oram_dat;
      end
    end
  end

  initial begin
    rst = 1'b1; cfg_start = 1'b0; cfg_msk = '0; cfg_base = '0;
    in_vld = '0; in_lst = '0; in_dat = '0; in_add = '0; oram_rdy = 1'b0;
    l_msk = '0; l_base = '0; vpct = 0; rpct = 100; stall_left = 0;
    for (int i = 0; i < N; i++) begin nb[i] = 0; hd[i] = 0; end
    model_reset();
    do_reset();

    // Single channel, three beats at base 0x100
    set_beats(16'h0001, 1);
    nb[0] = 3;
    for (int j = 0; j < 3; j++) badd[0][j] = 8'(j);
    run_layer(16'h0001, 10'h100, 100, 100);

    // All channels streaming, RAM always ready
    set_beats(16'hFFFF, 2);
    for (int i = 0; i < N; i++) nb[i] = 2;
    run_layer(16'hFFFF, 10'h040, 100, 100);

    // Five-cycle back-pressure on a held write
    set_beats(16'h0080, 1);
    nb[7] = 2;
    stall_left = 5;
    run_layer(16'h0080, 10'h200, 100, 100);
    stall_left = 0;

    // Address wrap: 0x3FE + 0x05
    set_beats(16'h0020, 1);
    badd[5][0] = 8'h05;
    run_layer(16'h0020, 10'h3FE, 100, 100);

    // Channel 3 masked off while requesting
    set_beats(16'hFFF7, 3);
    run_layer(16'hFFF7, 10'h155, 70, 80);

    // Empty mask
    set_beats(16'h0000, 1);
    run_layer(16'h0000, 10'h000, 100, 100);

    // Reset with a write pending
    set_beats(16'h0001, 1);
    nb[0] = 8;
    l_msk = 16'h0001; l_base = 10'h010; vpct = 100; rpct = 0;
    step(1'b1);
    step(1'b0);
    step(1'b0);
    chk("pending_before_rst", 32'(oram_vld), 32'd1);
    do_reset();
    set_beats(16'h0001, 3);
    run_layer(16'h0001, 10'h011, 100, 100);

    // Randomized layers
    for (int t = 0; t < 20; t++) begin
      logic [15:0] msk;
      msk = 16'($urandom);
      set_beats(msk, 5);
      run_layer(msk, 10'($urandom), int'($urandom_range(100, 30)), int'($urandom_range(100, 30)));
    end

    repeat (3) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
